// File: rtl/iic_reg_ctrl.sv
// Register-access sequencer for an IIC byte master: turns one register read/write
// command into the start / address / register / data / repeated-start byte sequence.
module iic_reg_ctrl #(
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_dev,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_err,
  output logic [7:0] m_data_in,
  output logic       m_start_flag,
  output logic       m_continue_flag,
  input  logic [7:0] m_data_out,
  input  logic       m_byte_done,
  input  logic       m_ack_check,
  input  logic       m_ack_check_vd,
  input  logic       m_trans_done,
  output logic [3:0] dbg_state_o
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    LAUNCH    = 4'd1,
    ADDR_W    = 4'd2,
    REG       = 4'd3,
    WDATA     = 4'd4,
    ADDR_R    = 4'd5,
    RDATA     = 4'd6,
    WAIT_STOP = 4'd7,
    RESP      = 4'd8
  } state_t;

  localparam logic [1:0] ERR_OK   = 2'd0;
  localparam logic [1:0] ERR_NACK = 2'd1;
  localparam logic [1:0] ERR_TMO  = 2'd2;

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state_q, state_d;
  logic             ready_q, ready_d;
  logic             rw_q, rw_d;
  logic [6:0]       dev_q, dev_d;
  logic [7:0]       reg_q, reg_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       data_q, data_d;
  logic             start_q, start_d;
  logic             cont_q, cont_d;
  logic [1:0]       err_q, err_d;
  logic [1:0]       rsp_err_q, rsp_err_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rdata_q, rdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic nack;
  logic busy;

  assign nack = m_ack_check_vd & ~m_ack_check;
  assign busy = (state_q != IDLE) && (state_q != RESP);

  always_comb begin
    state_d     = state_q;
    rw_d        = rw_q;
    dev_d       = dev_q;
    reg_d       = reg_q;
    wdata_d     = wdata_q;
    data_d      = data_q;
    start_d     = start_q;
    cont_d      = cont_q;
    err_d       = err_q;
    rsp_err_d   = rsp_err_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;

    if (busy) begin
      cnt_d = (m_byte_done || m_trans_done) ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (cmd_valid && ready_q) begin
          rw_d    = cmd_rw;
          dev_d   = cmd_dev;
          reg_d   = cmd_reg;
          wdata_d = cmd_wdata;
          data_d  = {cmd_dev, 1'b0};
          start_d = 1'b1;
          cont_d  = 1'b1;
          err_d   = ERR_OK;
          cnt_d   = '0;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        start_d = 1'b0;
        state_d = ADDR_W;
      end
      ADDR_W, REG, WDATA, ADDR_R: begin
        // A NACK ends the transfer even when byte_done arrives in the same cycle.
        if (nack) begin
          err_d   = ERR_NACK;
          start_d = 1'b0;
          cont_d  = 1'b0;
          state_d = WAIT_STOP;
        end else if (m_byte_done) begin
          case (state_q)
            ADDR_W: begin
              data_d  = reg_q;
              state_d = REG;
            end
            REG: begin
              if (rw_q) begin
                data_d  = {dev_q, 1'b1};
                start_d = 1'b1;
                cont_d  = 1'b1;
                state_d = ADDR_R;
              end else begin
                data_d  = wdata_q;
                cont_d  = 1'b0;
                state_d = WDATA;
              end
            end
            ADDR_R: begin
              start_d = 1'b0;
              cont_d  = 1'b0;
              state_d = RDATA;
            end
            default: state_d = WAIT_STOP;
          endcase
        end
      end
      RDATA: begin
        if (m_byte_done) begin
          rdata_d = m_data_out;
          state_d = WAIT_STOP;
        end
      end
      WAIT_STOP: begin
        if (m_trans_done) state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Stalled master: abandon the transfer; any read byte caught this cycle is discarded.
    if (busy && (cnt_q == CNT_MAX)) begin
      err_d   = ERR_TMO;
      start_d = 1'b0;
      cont_d  = 1'b0;
      rdata_d = rdata_q;
      state_d = RESP;
    end

    if ((state_d == RESP) && (state_q != RESP)) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = err_d;
    end
  end

  assign ready_d = (state_d == IDLE);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      rw_q        <= 1'b0;
      dev_q       <= '0;
      reg_q       <= '0;
      wdata_q     <= '0;
      data_q      <= '0;
      start_q     <= 1'b0;
      cont_q      <= 1'b0;
      err_q       <= ERR_OK;
      rsp_err_q   <= ERR_OK;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      rw_q        <= rw_d;
      dev_q       <= dev_d;
      reg_q       <= reg_d;
      wdata_q     <= wdata_d;
      data_q      <= data_d;
      start_q     <= start_d;
      cont_q      <= cont_d;
      err_q       <= err_d;
      rsp_err_q   <= rsp_err_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
    end
  end

  // cmd_valid/cmd_ready: a command transfers on a rising edge where both are high;
  // rsp_valid is a single-cycle pulse with no back-pressure.
  assign cmd_ready       = ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_err         = rsp_err_q;
  assign rsp_rdata       = rdata_q;
  assign m_data_in       = data_q;
  assign m_start_flag    = start_q;
  assign m_continue_flag = cont_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_iic_reg_ctrl.sv
// Bench for iic_reg_ctrl: behavioural IIC byte master plus scoreboards for the
// bus byte sequence and the command responses.
module tb_iic_reg_ctrl;

  localparam int LAT = 3;

  logic       clk;
  logic       rstn;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rw;
  logic [6:0] cmd_dev;
  logic [7:0] cmd_reg;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic [7:0] m_data_in;
  logic       m_start_flag;
  logic       m_continue_flag;
  logic [7:0] m_data_out;
  logic       m_byte_done;
  logic       m_ack_check;
  logic       m_ack_check_vd;
  logic       m_trans_done;
  logic [3:0] dbg_state_o;

  iic_reg_ctrl #(.TIMEOUT_CYC(100)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_rw         (cmd_rw),
    .cmd_dev        (cmd_dev),
    .cmd_reg        (cmd_reg),
    .cmd_wdata      (cmd_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .m_data_in      (m_data_in),
    .m_start_flag   (m_start_flag),
    .m_continue_flag(m_continue_flag),
    .m_data_out     (m_data_out),
    .m_byte_done    (m_byte_done),
    .m_ack_check    (m_ack_check),
    .m_ack_check_vd (m_ack_check_vd),
    .m_trans_done   (m_trans_done),
    .dbg_state_o    (dbg_state_o)
  );

  // clock / reset
  int cyc = 0;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state; bus events are {kind[3:0], byte}: 1 start, 2 data, 3 restart, 4 read, 5 stop
  logic [11:0] exp_ev_q[$];
  logic [9:0]  exp_q[$];
  int tests = 0;
  int fails = 0;
  int acc_cyc = 0;
  int last_rsp_cyc = 0;

  logic       hang = 1'b0;
  int         nack_idx = -1;
  logic [7:0] rd_val = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_ev(input logic [11:0] v);
    if (exp_ev_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL bus_ev: got unexpected %0h with empty queue", v);
    end else begin
      chk("bus_ev", {20'd0, v}, {20'd0, exp_ev_q.pop_front()});
    end
  endtask

  // response monitor
  always @(negedge clk) begin
    if (rstn && rsp_valid) begin
      last_rsp_cyc = cyc;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rsp: got unexpected err=%0d rdata=%0h", rsp_err, rsp_rdata);
      end else begin
        chk("rsp", {22'd0, rsp_err, rsp_rdata}, {22'd0, exp_q.pop_front()});
      end
    end
  end

  // behavioural byte master: latches the byte at start, reports each finished byte
  int         ms = 0;
  int         mcnt = 0;
  int         byte_idx = 0;
  logic [7:0] cur = 8'h00;
  logic       is_addr = 1'b0;
  logic       is_rs = 1'b0;
  logic       cont_cur = 1'b0;
  logic       last_nack = 1'b0;

  initial begin
    m_data_out = 8'h00;
    m_byte_done = 1'b0;
    m_ack_check = 1'b0;
    m_ack_check_vd = 1'b0;
    m_trans_done = 1'b0;
    forever begin
      @(negedge clk);
      m_byte_done = 1'b0;
      m_ack_check = 1'b0;
      m_ack_check_vd = 1'b0;
      m_trans_done = 1'b0;
      if (!rstn) begin
        ms = 0;
      end else begin
        case (ms)
          0: if (m_start_flag && !hang) begin
            cur = m_data_in; is_addr = 1'b1; is_rs = 1'b0; byte_idx = 0; mcnt = 0; ms = 1;
          end
          1: begin
            mcnt++;
            if (mcnt == LAT) begin
              check_ev({is_rs ? 4'd3 : (is_addr ? 4'd1 : 4'd2), cur});
              last_nack = (byte_idx == nack_idx);
              cont_cur = m_continue_flag;
              m_ack_check_vd = 1'b1;
              m_ack_check = !last_nack;
              m_byte_done = 1'b1;
              byte_idx++;
              ms = 4;
            end
          end
          4: begin
            mcnt = 0;
            if (last_nack) ms = 3;
            else if (is_addr && cur[0]) ms = 2;
            else if (m_start_flag) begin
              cur = m_data_in; is_addr = 1'b1; is_rs = 1'b1; ms = 1;
            end else if (cont_cur) begin
              cur = m_data_in; is_addr = 1'b0; is_rs = 1'b0; ms = 1;
            end else ms = 3;
          end
          2: begin
            mcnt++;
            if (mcnt == LAT) begin
              m_data_out = rd_val;
              m_byte_done = 1'b1;
              check_ev({4'd4, 8'h00});
              mcnt = 0;
              ms = 3;
            end
          end
          3: begin
            mcnt++;
            if (mcnt == 2) begin
              m_trans_done = 1'b1;
              check_ev({4'd5, 8'h00});
              ms = 0;
            end
          end
          default: ms = 0;
        endcase
      end
    end
  end

  // driver tasks
  task automatic do_cmd(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                        input logic [7:0] wd);
    int n;
    cmd_rw = rw; cmd_dev = dev; cmd_reg = rg; cmd_wdata = wd; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", cmd_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_ev_q.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("done_in_time", (n < 500), 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, cmd_ready, 1'b0);
    chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, "_rsp_err"}, rsp_err, 2'd0);
    chk({tag, "_rdata"}, rsp_rdata, 8'h00);
    chk({tag, "_data_in"}, m_data_in, 8'h00);
    chk({tag, "_start"}, m_start_flag, 1'b0);
    chk({tag, "_cont"}, m_continue_flag, 1'b0);
    chk({tag, "_state"}, dbg_state_o, 4'd0);
  endtask

  initial begin
    int n;
    int ready_bad;
    rstn = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0;
    cmd_dev = 7'h00; cmd_reg = 8'h00; cmd_wdata = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    rstn = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", cmd_ready, 1'b1);

    // plain write
    exp_ev_q.push_back({4'd1, 8'hA0}); exp_ev_q.push_back({4'd2, 8'h10});
    exp_ev_q.push_back({4'd2, 8'hA5}); exp_ev_q.push_back({4'd5, 8'h00});
    exp_q.push_back({2'd0, 8'h00});
    do_cmd(1'b0, 7'h50, 8'h10, 8'hA5);
    wait_done();

    // plain read with repeated start
    rd_val = 8'h3C;
    exp_ev_q.push_back({4'd1, 8'hA0}); exp_ev_q.push_back({4'd2, 8'h22});
    exp_ev_q.push_back({4'd3, 8'hA1}); exp_ev_q.push_back({4'd4, 8'h00});
    exp_ev_q.push_back({4'd5, 8'h00});
    exp_q.push_back({2'd0, 8'h3C});
    do_cmd(1'b1, 7'h50, 8'h22, 8'h00);
    wait_done();

    // NACK on the register byte
    nack_idx = 1;
    exp_ev_q.push_back({4'd1, 8'hA0}); exp_ev_q.push_back({4'd2, 8'h33});
    exp_ev_q.push_back({4'd5, 8'h00});
    exp_q.push_back({2'd1, 8'h3C});
    do_cmd(1'b0, 7'h50, 8'h33, 8'h77);
    wait_done();

    // NACK on the device address
    nack_idx = 0;
    exp_ev_q.push_back({4'd1, 8'h24}); exp_ev_q.push_back({4'd5, 8'h00});
    exp_q.push_back({2'd1, 8'h3C});
    do_cmd(1'b1, 7'h12, 8'h01, 8'h00);
    wait_done();

    // NACK on the read address after repeated start
    nack_idx = 2;
    exp_ev_q.push_back({4'd1, 8'hA0}); exp_ev_q.push_back({4'd2, 8'h22});
    exp_ev_q.push_back({4'd3, 8'hA1}); exp_ev_q.push_back({4'd5, 8'h00});
    exp_q.push_back({2'd1, 8'h3C});
    do_cmd(1'b1, 7'h50, 8'h22, 8'h00);
    wait_done();

    // NACK on the write data byte
    exp_ev_q.push_back({4'd1, 8'hA0}); exp_ev_q.push_back({4'd2, 8'h10});
    exp_ev_q.push_back({4'd2, 8'hA5}); exp_ev_q.push_back({4'd5, 8'h00});
    exp_q.push_back({2'd1, 8'h3C});
    do_cmd(1'b0, 7'h50, 8'h10, 8'hA5);
    wait_done();
    nack_idx = -1;

    // second read, different device
    rd_val = 8'h5A;
    exp_ev_q.push_back({4'd1, 8'hD0}); exp_ev_q.push_back({4'd2, 8'h75});
    exp_ev_q.push_back({4'd3, 8'hD1}); exp_ev_q.push_back({4'd4, 8'h00});
    exp_ev_q.push_back({4'd5, 8'h00});
    exp_q.push_back({2'd0, 8'h5A});
    do_cmd(1'b1, 7'h68, 8'h75, 8'h00);
    wait_done();

    // stalled master: timeout response 100 cycles after accept
    hang = 1'b1;
    exp_q.push_back({2'd2, 8'h5A});
    do_cmd(1'b0, 7'h50, 8'h10, 8'hA5);
    wait_done();
    chk("timeout_latency", last_rsp_cyc - acc_cyc, 100);
    hang = 1'b0;

    // cmd_valid held across completion of the first command
    rd_val = 8'hC3;
    exp_ev_q.push_back({4'd1, 8'hA0}); exp_ev_q.push_back({4'd2, 8'h01});
    exp_ev_q.push_back({4'd2, 8'hFF}); exp_ev_q.push_back({4'd5, 8'h00});
    exp_q.push_back({2'd0, 8'h5A});
    exp_ev_q.push_back({4'd1, 8'hA0}); exp_ev_q.push_back({4'd2, 8'h02});
    exp_ev_q.push_back({4'd3, 8'hA1}); exp_ev_q.push_back({4'd4, 8'h00});
    exp_ev_q.push_back({4'd5, 8'h00});
    exp_q.push_back({2'd0, 8'hC3});
    cmd_rw = 1'b0; cmd_dev = 7'h50; cmd_reg = 8'h01; cmd_wdata = 8'hFF; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("hold_accept1", cmd_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    cmd_rw = 1'b1; cmd_reg = 8'h02; cmd_wdata = 8'h00;
    ready_bad = 0;
    n = 0;
    while (!rsp_valid && n < 300) begin
      if (cmd_ready) ready_bad++;
      @(negedge clk);
      n++;
    end
    chk("hold_rsp_seen", rsp_valid, 1'b1);
    chk("hold_ready_low_first", ready_bad, 0);
    chk("hold_ready_low_resp", cmd_ready, 1'b0);
    @(negedge clk);
    chk("hold_ready_after_resp", cmd_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("hold_accept2_launch", dbg_state_o, 4'd1);
    wait_done();

    // reset in the middle of ADDR_R
    exp_ev_q.push_back({4'd1, 8'hA0}); exp_ev_q.push_back({4'd2, 8'h44});
    do_cmd(1'b1, 7'h50, 8'h44, 8'h00);
    n = 0;
    while (dbg_state_o != 4'd5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reach_addr_r", dbg_state_o, 4'd5);
    rstn = 1'b0;
    @(negedge clk);
    chk_reset_outputs("mid");
    @(negedge clk);
    rstn = 1'b1;
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) n++;
    end
    chk("no_rsp_after_abort", n, 0);
    chk("ready_after_abort", cmd_ready, 1'b1);

    // fresh command after the abort; read data was cleared by reset
    exp_ev_q.push_back({4'd1, 8'h7E}); exp_ev_q.push_back({4'd2, 8'h80});
    exp_ev_q.push_back({4'd2, 8'h00}); exp_ev_q.push_back({4'd5, 8'h00});
    exp_q.push_back({2'd0, 8'h00});
    do_cmd(1'b0, 7'h3F, 8'h80, 8'h00);
    wait_done();

    chk("ev_q_empty", exp_ev_q.size(), 0);
    chk("rsp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/iic_reg_ctrl.md
IIC_REG_CTRL -- requirements
Module: iic_reg_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 2000000, max clk cycles allowed between master progress events (byte_done or trans_done).
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port cmd_valid  input  1  command request.
REQ-005 SHALL have port cmd_ready  output  1  high when idle and able to accept a command.
REQ-006 SHALL have port cmd_rw  input  1  0 = register write, 1 = register read.
REQ-007 SHALL have port cmd_dev  input  7  7-bit slave address.
REQ-008 SHALL have port cmd_reg  input  8  register address.
REQ-009 SHALL have port cmd_wdata  input  8  write data.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL have port rsp_rdata  output  8  read data, valid with rsp_valid when cmd_rw=1.
REQ-012 SHALL have port rsp_err  output  2  status with rsp_valid: 0 ok, 1 NACK, 2 timeout.
REQ-013 SHALL have port m_data_in  output  8  byte to IIC byte master.
REQ-014 SHALL have port m_start_flag  output  1  start / repeated-start request to master.
REQ-015 SHALL have port m_continue_flag  output  1  more bytes follow current byte.
REQ-016 SHALL have ports m_data_out (input, 8), m_byte_done, m_ack_check, m_ack_check_vd, m_trans_done (inputs, 1) from master.

Function
REQ-017 SHALL accept a command when cmd_valid & cmd_ready; latch all cmd_* fields; cmd_ready low until return to IDLE.
REQ-018 SHALL implement FSM states IDLE, LAUNCH, ADDR_W, REG, WDATA, ADDR_R, RDATA, WAIT_STOP, RESP.
REQ-019 SHALL go IDLE->LAUNCH on accept; LAUNCH asserts m_start_flag exactly one cycle with m_data_in={dev,1'b0}, m_continue_flag=1, then ADDR_W.
REQ-020 SHALL advance ADDR_W->REG on m_byte_done, loading m_data_in=reg in the same cycle; continue_flag stays 1.
REQ-021 Write: SHALL go REG->WDATA on m_byte_done, loading m_data_in=wdata, m_continue_flag=0; WDATA->WAIT_STOP on m_byte_done.
REQ-022 Read: on REG m_byte_done SHALL load m_data_in={dev,1'b1}, set m_start_flag=1 (held), m_continue_flag=1, enter ADDR_R.
REQ-023 SHALL drop m_start_flag on the m_byte_done ending ADDR_R, set m_continue_flag=0, enter RDATA.
REQ-024 SHALL capture m_data_out into rsp_rdata on the m_byte_done ending RDATA, then enter WAIT_STOP (master NACKs and stops since continue_flag=0).
REQ-025 SHALL, in ADDR_W/REG/WDATA/ADDR_R, treat m_ack_check_vd=1 with m_ack_check=0 as NACK: latch err=1, clear m_continue_flag and m_start_flag, enter WAIT_STOP.
REQ-026 SHALL go WAIT_STOP->RESP on m_trans_done; RESP pulses rsp_valid one cycle with rsp_err, then IDLE.
REQ-027 SHALL run a progress counter in all states except IDLE/RESP, cleared on accept, m_byte_done and m_trans_done; on reaching TIMEOUT_CYC-1 SHALL set err=2 and enter RESP directly.
REQ-028 SHALL hold m_data_in stable except at the load points above; ignore m_byte_done/m_trans_done in IDLE.
REQ-029 NACK and timeout in same cycle: timeout SHALL win (err=2); m_byte_done coincident with NACK: NACK wins.
REQ-030 rsp_rdata SHALL retain last read value; on write or error responses it is unchanged.

Reset
REQ-031 On clk edge with rstn=0: state=IDLE, cmd_ready=0 during reset then 1 next cycle, rsp_valid=0, rsp_err=0, rsp_rdata=0, m_data_in=0, m_start_flag=0, m_continue_flag=0, counter=0; mid-operation reset SHALL abort without rsp_valid.

Verification
REQ-032 Write dev=0x50 reg=0x10 data=0xA5 with ACKing slave model -> bytes 0xA0,0x10,0xA5 on bus, stop, rsp_valid with rsp_err=0.
REQ-033 Read dev=0x50 reg=0x22, slave returns 0x3C -> bytes 0xA0,0x22, repeated start, 0xA1, NACK, stop; rsp_rdata=0x3C, rsp_err=0.
REQ-034 Slave NACKs reg byte -> no further bytes, stop issued, rsp_err=1, rsp_rdata unchanged.
REQ-035 TIMEOUT_CYC=100, master model never returns byte_done -> rsp_valid at cycle 100 after accept, rsp_err=2.
REQ-036 rstn low mid-ADDR_R -> all outputs to reset values next edge, no rsp_valid; new command accepted after release.
REQ-037 cmd_valid held high across completion -> second command accepted only after RESP cycle, cmd_ready low throughout first.
